// File: rtl/sdram_ioctl_bridge_pkg.sv
// Shared types and constants for the IO-controller (port C) SDRAM bridge.
package sdram_pkg;

    localparam int unsigned ADDR_W          = 25;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned SLOT_CYCLES_MIN = 15;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ioctl_req_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bridge_state_t;

endpackage

// File: rtl/sdram_ioctl_bridge_if.sv
// Request/response channel between the download/upload logic and the bridge.
interface sdram_ioctl_bridge_if;
    import sdram_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/sdram_ioctl_bridge_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] countNext;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdata  = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (doPush && !doPop)
            countNext = count + 1'b1;
        else if (doPop && !doPush)
            countNext = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + 1'b1;
            if (doPop)
                rdPtr <= rdPtr + 1'b1;
            count <= countNext;
            full  <= (countNext == CNT_W'(DEPTH));
            empty <= (countNext == '0);
        end
    end

endmodule

// File: rtl/sdram_ioctl_bridge.sv
// Queues IO-controller byte requests and issues them to SDRAM port C with the
// toggle handshake; completion is timed by a fixed slot counter.
module sdram_ioctl_bridge
    import sdram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SLOT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_ioctl_bridge_if.slave  ioctl,
    output logic                 busy,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_oewe,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_din,
    input  logic [DATA_W-1:0]    mem_dout
);
    localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    bridge_state_t     state;
    logic [SLOT_W-1:0] slotCnt;
    ioctl_req_t        pushReq;
    ioctl_req_t        headReq;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [FCNT_W-1:0] fifoCount;

    assign pushReq = '{we: ioctl.req_we, addr: ioctl.req_addr, data: ioctl.req_data};

    // req_ready comes straight from the registered full flag.
    assign ioctl.req_ready = !fifoFull;
    assign fifoPush        = ioctl.req_valid && !fifoFull;
    assign fifoPop         = (state == ST_IDLE) && !fifoEmpty;
    assign busy            = (fifoCount != '0) || (state != ST_IDLE);

    sync_fifo #(
        .WIDTH ($bits(ioctl_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (pushReq),
        .rdata (headReq),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            slotCnt         <= '0;
            mem_oewe        <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_din         <= '0;
            ioctl.rsp_valid <= 1'b0;
            ioctl.rsp_data  <= '0;
        end else begin
            ioctl.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        mem_addr <= headReq.addr;
                        mem_we   <= headReq.we;
                        mem_din  <= headReq.data;
                        mem_oewe <= !mem_oewe;
                        slotCnt  <= SLOT_W'(SLOT_CYCLES - 1);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Address/data stay put for the whole slot; the controller samples them late.
                    if (slotCnt == '0) begin
                        if (!mem_we) begin
                            ioctl.rsp_data  <= mem_dout;
                            ioctl.rsp_valid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        slotCnt <= slotCnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ioctl_bridge.sv
// Directed self-checking bench for sdram_ioctl_bridge with a toggle-driven SDRAM model.
module tb_sdram_ioctl_bridge;
    import sdram_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_oewe;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] memDout = '0;

    sdram_ioctl_bridge_if ioctl ();

    sdram_ioctl_bridge #(
        .FIFO_DEPTH  (4),
        .SLOT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ioctl    (ioctl.slave),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_oewe (mem_oewe),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (memDout)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    int stabErr = 0;
    bit monEn  = 1'b0;

    logic [7:0]  sdram [logic [24:0]];
    int          togCyc[$];
    logic [24:0] togAddr[$];
    logic        togWe[$];
    logic [7:0]  togDin[$];
    int          rspCyc[$];
    logic [7:0]  rspData[$];
    logic        prevOewe = 1'b0;
    logic [33:0] prevBus = '0;

    always @(posedge clk) cyc++;

    // Behavioural port-C model: acts on each oewe toggle, checks bus stability between toggles.
    always @(negedge clk) begin
        if (monEn) begin
            if (mem_oewe !== prevOewe) begin
                togCyc.push_back(cyc);
                togAddr.push_back(mem_addr);
                togWe.push_back(mem_we);
                togDin.push_back(mem_din);
                if (mem_we)
                    sdram[mem_addr] = mem_din;
                else
                    memDout = sdram.exists(mem_addr) ? sdram[mem_addr] : 8'h00;
            end else if ({mem_we, mem_addr, mem_din} !== prevBus) begin
                stabErr++;
            end
            if (ioctl.rsp_valid) begin
                rspCyc.push_back(cyc);
                rspData.push_back(ioctl.rsp_data);
            end
        end
        prevOewe = mem_oewe;
        prevBus  = {mem_we, mem_addr, mem_din};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushReq(input logic we, input logic [24:0] addr, input logic [7:0] data);
        int n = 0;
        ioctl.req_valid = 1'b1;
        ioctl.req_we    = we;
        ioctl.req_addr  = addr;
        ioctl.req_data  = data;
        while (!ioctl.req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!ioctl.req_ready)
            check("push_timeout", 32'(ioctl.req_ready), 32'd1);
        tick();
        ioctl.req_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCyc);
        int n = 0;
        while (busy && n < maxCyc) begin
            tick();
            n++;
        end
        check({"idle_", tag}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int rb;
        int firstStall;
        int n;
        bit readyLow;
        logic prevO;

        ioctl.req_valid = 1'b0;
        ioctl.req_we    = 1'b0;
        ioctl.req_addr  = '0;
        ioctl.req_data  = '0;
        sdram[25'h10] = 8'h3C;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        monEn = 1'b1;

        check("rst_ready", 32'(ioctl.req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oewe", 32'(mem_oewe), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_rsp", {23'd0, ioctl.rsp_valid, ioctl.rsp_data}, 32'd0);
        check("rst_we_din", {23'd0, mem_we, mem_din}, 32'd0);

        // Single write
        pushReq(1'b1, 25'h0001234, 8'hA5);
        check("wr_busy_queued", 32'(busy), 32'd1);
        tick();
        check("wr_oewe", 32'(mem_oewe), 32'd1);
        check("wr_bus", {mem_we, mem_addr, mem_din[5:0]}, {1'b1, 25'h0001234, 6'h25});
        check("wr_din", 32'(mem_din), 32'hA5);
        repeat (15) tick();
        check("wr_busy_end_slot", 32'(busy), 32'd1);
        check("wr_addr_held", 32'(mem_addr), 32'h1234);
        tick();
        check("wr_busy_fall", 32'(busy), 32'd0);
        check("wr_toggles", 32'(togCyc.size()), 32'd1);
        check("wr_no_rsp", 32'(rspCyc.size()), 32'd0);

        // Single read
        base = togCyc.size();
        pushReq(1'b0, 25'h0000010, 8'h00);
        waitIdle("rd", 100);
        repeat (2) tick();
        check("rd_toggles", 32'(togCyc.size()), 32'(base + 1));
        check("rd_rsp_count", 32'(rspCyc.size()), 32'd1);
        check("rd_latency", 32'(rspCyc[0] - togCyc[base]), 32'd16);
        check("rd_data", 32'(rspData[0]), 32'h3C);

        // Burst of six writes with req_valid held high
        base = togCyc.size();
        firstStall = -1;
        ioctl.req_valid = 1'b1;
        ioctl.req_we    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ioctl.req_addr = 25'h200 + 25'(i);
            ioctl.req_data = 8'h50 + 8'(i);
            n = 0;
            while (!ioctl.req_ready && n < 100) begin
                if (firstStall < 0)
                    firstStall = i;
                tick();
                n++;
            end
            tick();
        end
        ioctl.req_valid = 1'b0;
        check("burst_first_stall", 32'(firstStall), 32'd5);
        waitIdle("burst", 300);
        check("burst_toggles", 32'(togCyc.size()), 32'(base + 6));
        for (int i = 0; i < 6; i++) begin
            check("burst_addr", 32'(togAddr[base + i]), 32'h200 + 32'(i));
            check("burst_din", 32'(togDin[base + i]), 32'h50 + 32'(i));
            if (i > 0)
                check("burst_spacing", 32'(togCyc[base + i] - togCyc[base + i - 1]), 32'd17);
        end
        check("burst_no_rsp", 32'(rspCyc.size()), 32'd1);

        // Write then read of the same address
        base = togCyc.size();
        pushReq(1'b1, 25'h100, 8'h11);
        pushReq(1'b0, 25'h100, 8'h00);
        waitIdle("wr_rd", 100);
        repeat (2) tick();
        check("wrrd_toggles", 32'(togCyc.size()), 32'(base + 2));
        check("wrrd_order", {30'd0, togWe[base], togWe[base + 1]}, 32'b10);
        check("wrrd_spacing", 32'(togCyc[base + 1] - togCyc[base]), 32'd17);
        check("wrrd_rsp_count", 32'(rspCyc.size()), 32'd2);
        check("wrrd_data", 32'(rspData[1]), 32'h11);

        // Reset five cycles into a read slot with two requests queued
        base = togCyc.size();
        rb = rspCyc.size();
        pushReq(1'b0, 25'h10, 8'h00);
        pushReq(1'b1, 25'h400, 8'h77);
        pushReq(1'b1, 25'h401, 8'h78);
        repeat (4) tick();
        check("rst_mid_toggled", 32'(mem_oewe), 32'd1);
        monEn = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_oewe", 32'(mem_oewe), 32'd0);
        check("rst_mid_ready", 32'(ioctl.req_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rsp", 32'(ioctl.rsp_valid), 32'd0);
        tick();
        monEn = 1'b1;
        repeat (20) tick();
        check("rst_mid_no_issue", 32'(togCyc.size()), 32'(base + 1));
        check("rst_mid_no_rsp", 32'(rspCyc.size()), 32'(rb));
        check("rst_mid_oewe_hold", 32'(mem_oewe), 32'd0);

        // Full FIFO with a pop in the same cycle as a pending request
        base = togCyc.size();
        for (int i = 0; i < 5; i++)
            pushReq(1'b1, 25'h300 + 25'(i), 8'h60 + 8'(i));
        check("full_ready", 32'(ioctl.req_ready), 32'd0);
        ioctl.req_valid = 1'b1;
        ioctl.req_we    = 1'b1;
        ioctl.req_addr  = 25'h305;
        ioctl.req_data  = 8'h65;
        readyLow = 1'b1;
        n = 0;
        while (n < 100) begin
            prevO = mem_oewe;
            if (ioctl.req_ready)
                readyLow = 1'b0;
            tick();
            n++;
            if (mem_oewe != prevO)
                break;
        end
        check("full_hold_low", 32'(readyLow), 32'd1);
        check("full_pop_toggles", 32'(togCyc.size() + 1), 32'(base + 2) + 32'(mem_oewe != prevO ? 0 : 1));
        check("ready_after_pop", 32'(ioctl.req_ready), 32'd1);
        tick();
        ioctl.req_valid = 1'b0;
        check("refull_ready", 32'(ioctl.req_ready), 32'd0);
        waitIdle("full", 300);
        check("full_toggles", 32'(togCyc.size()), 32'(base + 6));
        for (int i = 0; i < 6; i++)
            check("full_order", 32'(togAddr[base + i]), 32'h300 + 32'(i));

        check("bus_stable", 32'(stabErr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
